// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, types and sign-extension helper for psum_accum.
package psum_pkg;
  localparam int BW_PSUM = 19;
  localparam int BW_ACC = 24;
  localparam int MAC_LAT = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  typedef logic signed [BW_PSUM-1:0] psum_t;
  typedef logic signed [BW_ACC-1:0] acc_t;
  function automatic acc_t sext(input psum_t p);
    return {{(BW_ACC-BW_PSUM){p[BW_PSUM-1]}}, p};
  endfunction
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: FIFO_DEPTH x BW_ACC result buffer; upstream credit keeps pushes off a full FIFO.
module psum_fifo
  import psum_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  acc_t             din,
  output acc_t             dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  acc_t mem_q [FIFO_DEPTH];
  acc_t mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (reset_n && push && !pop) assert (cnt_q < CNT_W'(FIFO_DEPTH));
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/psum_accum.sv
// psum_accum: group accumulator for MAC psums with credit-controlled result FIFO.
// Define PSUM_ACC_RELU_EN to clamp negative pushed sums to zero.
module psum_accum
  import psum_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [BW_PSUM-1:0] psum_in,
  output logic [BW_ACC-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               ovf_err
);
  logic [MAC_LAT-1:0] v_q, v_d, l_q, l_d;
  acc_t acc_q, acc_d, ext, sum, push_val, fifo_dout;
  logic [CNT_W-1:0] pend_q, pend_d, fifo_cnt;
  logic [CNT_W:0] credit;
  logic ovf_q, ovf_d, issue, acc_en, push, pop, fifo_empty;
  assign credit = {1'b0, fifo_cnt} + {1'b0, pend_q};
  assign in_ready = credit < (CNT_W+1)'(FIFO_DEPTH);
  always_comb begin
    issue = in_valid & in_ready;
    v_d = MAC_LAT'({v_q, issue});
    l_d = MAC_LAT'({l_q, in_last});
    acc_en = v_q[MAC_LAT-1];
    push = acc_en & l_q[MAC_LAT-1];
    ext = sext(psum_in);
    sum = acc_q + ext;
    acc_d = !acc_en ? acc_q : push ? '0 : sum;
    // signed overflow: equal operand signs, result sign differs
    ovf_d = ovf_q | (acc_en & (acc_q[BW_ACC-1] == ext[BW_ACC-1]) & (sum[BW_ACC-1] != acc_q[BW_ACC-1]));
    pend_d = pend_q + CNT_W'(issue & in_last) - CNT_W'(push);
`ifdef PSUM_ACC_RELU_EN
    push_val = sum[BW_ACC-1] ? '0 : sum;
`else
    push_val = sum;
`endif
    pop = out_valid & out_ready;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      l_q <= '0;
      acc_q <= '0;
      pend_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      v_q <= v_d;
      l_q <= l_d;
      acc_q <= acc_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  end
  psum_fifo u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (push_val),
    .dout   (fifo_dout),
    .count  (fifo_cnt),
    .empty  (fifo_empty)
  );
  assign out_valid = !fifo_empty;
  assign out_data = fifo_dout;
  assign ovf_err = ovf_q;
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed checks of accumulation, credit, overflow and reset for psum_accum.
module tb_psum_accum;
  logic clk = 1'b0;
  logic reset_n, in_valid, in_last, in_ready, out_valid, out_ready, ovf_err;
  logic [18:0] psum_in, feed, p1, p2;
  logic [23:0] out_data;
  int checks = 0;
  int passed = 0;
  psum_accum dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .psum_in  (psum_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf_err  (ovf_err)
  );
  always #5 clk = ~clk;
  // two-stage MAC stand-in: data offered at issue shows up MAC_LAT cycles later
  always @(posedge clk) begin
    p1 <= feed;
    p2 <= p1;
  end
  assign psum_in = p2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [18:0] v, input logic last);
    in_valid = 1'b1;
    in_last = last;
    feed = v;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    feed = '0;
  endtask
  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic get_result(input string tag, input logic [23:0] exp);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    pop();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    feed = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    // 8 chunks of +100, latency of 3 cycles from issue of last
    for (int i = 0; i < 8; i++) issue(19'd100, i == 7);
    chk("lat1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat3_valid", 32'(out_valid), 32'd1);
    chk("g8_data", 32'(out_data), 32'd800);
    tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", 32'(out_data), 32'd800);
    pop();
    chk("g8_popped", 32'(out_valid), 32'd0);
    // mixed signs
    issue(19'h40000, 1'b0);
    issue(19'd5, 1'b0);
    issue(19'h7FFFF, 1'b1);
`ifdef PSUM_ACC_RELU_EN
    get_result("mixed", 24'h000000);
`else
    get_result("mixed", 24'hFC0004);
`endif
    // credit: four single-chunk groups fill the FIFO while out_ready=0
    for (int i = 1; i <= 4; i++) begin
      chk("credit_rdy", 32'(in_ready), 32'd1);
      issue(19'(i), 1'b1);
    end
    chk("credit_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_last = 1'b1;
    feed = 19'd99;
    repeat (5) begin
      tick();
      chk("credit_hold", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    feed = '0;
    chk("credit_q_valid", 32'(out_valid), 32'd1);
    chk("credit_q1", 32'(out_data), 32'd1);
    pop();
    chk("credit_back", 32'(in_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      chk("credit_qn", 32'(out_data), 32'(i));
      pop();
    end
    repeat (4) tick();
    chk("credit_empty", 32'(out_valid), 32'd0);
    // 16 x 0x3FFFF stays in range, 33 x 0x3FFFF wraps
    for (int i = 0; i < 16; i++) issue(19'h3FFFF, i == 15);
    get_result("big16", 24'h3FFFF0);
    chk("big16_ovf", 32'(ovf_err), 32'd0);
    for (int i = 0; i < 33; i++) issue(19'h3FFFF, i == 32);
`ifdef PSUM_ACC_RELU_EN
    get_result("wrap33", 24'h000000);
`else
    get_result("wrap33", 24'h83FFDF);
`endif
    chk("wrap33_ovf", 32'(ovf_err), 32'd1);
    issue(19'd3, 1'b1);
    get_result("after_wrap", 24'd3);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    // reset mid-group with a queued result and two psums in flight
    issue(19'd50, 1'b1);
    issue(19'd5, 1'b0);
    issue(19'd10, 1'b0);
    issue(19'd20, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_err), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    issue(19'd7, 1'b0);
    issue(19'd8, 1'b1);
    get_result("post_rst", 24'd15);
    chk("post_rst_ovf", 32'(ovf_err), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
